// File: rtl/branch_resolver.sv
// Prediction-loop closer: queues IF-side predictions in order, compares each against
// its EX resolution, and emits registered predictor training and mispredict redirects.
module branch_resolver #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_valid_i,
   input  logic [AW-1:0] push_pc_i,
   input  logic          push_je_i,
   input  logic [AW-1:0] push_jdest_i,
   output logic          full_o,
   input  logic          ex_valid_i,
   input  logic [AW-1:0] ex_pc_i,
   input  logic          ex_is_jmp_i,
   input  logic          ex_taken_i,
   input  logic [AW-1:0] ex_target_i,
   output logic          upd_valid_o,
   output logic [AW-1:0] upd_pc_o,
   output logic [AW-1:0] upd_dest_o,
   output logic          upd_taken_o,
   output logic          flush_o,
   output logic [AW-1:0] redirect_pc_o,
   output logic          err_o,
   output logic [31:0]   branch_cnt_o,
   output logic [31:0]   mispred_cnt_o
);
   localparam int          PW      = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   logic [AW-1:0] pc_mem_q    [DEPTH];
   logic [AW-1:0] jdest_mem_q [DEPTH];
   logic          je_mem_q    [DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
   logic          flush_q, flush_d, err_q, err_d;
   logic [AW-1:0] upd_pc_q, upd_pc_d, upd_dest_q, upd_dest_d, redirect_q, redirect_d;
   logic [31:0]   branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

   logic          push_ok_s, pop_s, mispredict_s, empty_s;
   logic          head_je_s;
   logic [AW-1:0] head_pc_s, head_jdest_s;

   assign full_o    = (count_q == DEPTH_C);
   assign empty_s   = (count_q == {(PW+1){1'b0}});
   assign push_ok_s = push_valid_i & ~full_o;
   assign pop_s     = ex_valid_i & ~empty_s;

   assign head_pc_s    = pc_mem_q[rd_ptr_q];
   assign head_je_s    = je_mem_q[rd_ptr_q];
   assign head_jdest_s = jdest_mem_q[rd_ptr_q];

   // Head-entry compare; a non-branch is only wrong if it was predicted taken.
   always_comb begin
      mispredict_s = 1'b0;
      if (pop_s) begin
         if (ex_is_jmp_i) begin
            mispredict_s = (ex_taken_i != head_je_s) |
                           (ex_taken_i & (ex_target_i != head_jdest_s));
         end else begin
            mispredict_s = head_je_s;
         end
      end else begin
         mispredict_s = 1'b0;
      end
   end

   // FIFO pointer/count next state; a mispredict empties the queue and drops any push.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (mispredict_s) begin
         rd_ptr_d = wr_ptr_q;
         wr_ptr_d = wr_ptr_q;
         count_d  = {(PW+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Training, redirect, error and counter next state.
   always_comb begin
      upd_valid_d   = pop_s & ex_is_jmp_i;
      flush_d       = mispredict_s;
      upd_pc_d      = upd_pc_q;
      upd_dest_d    = upd_dest_q;
      upd_taken_d   = upd_taken_q;
      redirect_d    = redirect_q;
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      err_d = err_q | (ex_valid_i & empty_s) | (pop_s & (head_pc_s != ex_pc_i));
      if (pop_s) begin
         upd_pc_d    = ex_pc_i;
         upd_dest_d  = ex_target_i;
         upd_taken_d = ex_taken_i;
         redirect_d  = ex_taken_i ? ex_target_i : (ex_pc_i + AW'(4));
         if (ex_is_jmp_i) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
         end else begin
            branch_cnt_d = branch_cnt_q;
         end
         if (mispredict_s) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
         end else begin
            mispred_cnt_d = mispred_cnt_q;
         end
      end else begin
         upd_pc_d = upd_pc_q;
      end
   end

   // Prediction storage; validity is tracked by the pointers, so no reset is needed.
   always_ff @(posedge clk_i) begin
      if (push_ok_s && !mispredict_s) begin
         pc_mem_q[wr_ptr_q]    <= push_pc_i;
         je_mem_q[wr_ptr_q]    <= push_je_i;
         jdest_mem_q[wr_ptr_q] <= push_jdest_i;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         upd_valid_q   <= 1'b0;
         upd_taken_q   <= 1'b0;
         flush_q       <= 1'b0;
         err_q         <= 1'b0;
         upd_pc_q      <= '0;
         upd_dest_q    <= '0;
         redirect_q    <= '0;
         branch_cnt_q  <= 32'd0;
         mispred_cnt_q <= 32'd0;
      end else begin
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         upd_valid_q   <= upd_valid_d;
         upd_taken_q   <= upd_taken_d;
         flush_q       <= flush_d;
         err_q         <= err_d;
         upd_pc_q      <= upd_pc_d;
         upd_dest_q    <= upd_dest_d;
         redirect_q    <= redirect_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign upd_valid_o   = upd_valid_q;
   assign upd_pc_o      = upd_pc_q;
   assign upd_dest_o    = upd_dest_q;
   assign upd_taken_o   = upd_taken_q;
   assign flush_o       = flush_q;
   assign redirect_pc_o = redirect_q;
   assign err_o         = err_q;
   assign branch_cnt_o  = branch_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;
endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Sits beside the IF-side branch predictor and closes the prediction loop.
- Each prediction issued at IF is recorded in a small in-order FIFO. When the matching instruction resolves in EX, its entry is popped and compared with the actual outcome.
- Outputs: the registered training update for the predictor (pc_ex/is_jmp/dest/jmp_res) and a registered flush/redirect to the front end on mispredict.
- Also keeps branch and mispredict counters for performance debug.

Parameters:
- DEPTH, 4, prediction FIFO entries (power of two, ≥2).
- AW, 32, instruction address width (matches `InstAddrBus).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- push_valid  in  1  IF issues an instruction with its prediction
- push_pc  in  AW  PC of the issued instruction
- push_je  in  1  predictor said taken
- push_jdest  in  AW  predicted target
- full  out  1  FIFO full; IF must stall
- ex_valid  in  1  an instruction resolves in EX this cycle
- ex_pc  in  AW  its PC
- ex_is_jmp  in  1  instruction is a branch/jump
- ex_taken  in  1  actual direction
- ex_target  in  AW  actual target
- upd_valid  out  1  predictor update strobe (drives is_jmp)
- upd_pc  out  AW  to predictor pc_ex
- upd_dest  out  AW  to predictor dest
- upd_taken  out  1  to predictor jmp_res
- flush  out  1  one-cycle mispredict flush
- redirect_pc  out  AW  fetch restart address, valid with flush
- err  out  1  sticky protocol error
- branch_cnt  out  32  resolved branches
- mispred_cnt  out  32  mispredicts

Behaviour:
- Reset (synchronous, active-high): FIFO empty (rd_ptr = wr_ptr = count = 0); full = 0. All registered outputs are 0: upd_*, flush, redirect_pc, err, and both counters. Reset mid-operation discards every entry.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH; count is 0..DEPTH.
  - full = (count == DEPTH), combinational from count.
  - Push accepted when push_valid && !full. A push while full is dropped; IF is responsible for stalling.
  - Pop occurs when ex_valid && count != 0.
  - Push and pop in the same cycle: both occur and count is unchanged. While full, the push is still rejected even if a pop happens that cycle.
- Resolution (combinational compare on head entry, results registered; 1-cycle latency):
  - mispredict = ex_is_jmp ? (ex_taken != je_h) || (ex_taken && ex_target != jdest_h) : je_h.
  - Next cycle:
    - upd_valid = ex_is_jmp.
    - upd_pc = ex_pc.
    - upd_dest = ex_target.
    - upd_taken = ex_taken.
    - flush = mispredict.
    - redirect_pc = ex_taken ? ex_target : ex_pc + 4 (mod 2^AW).
  - Cycles without a pop: upd_valid = 0, flush = 0. upd_pc, upd_dest and redirect_pc hold their previous values.
- Mispredict: on the same edge that registers flush, the FIFO is cleared (count = 0, rd_ptr = wr_ptr) and any same-cycle push is discarded.
- External flush: none; clearing comes only from rst or mispredict.
- Errors (err is sticky until rst): set when ex_valid with count == 0 (no pop, no update, no flush that cycle), or when the popped head PC != ex_pc. On a PC mismatch, resolution proceeds normally using the head entry.
- Counters: each pop increments branch_cnt if ex_is_jmp, and mispred_cnt if mispredict. Both wrap at 2^32.

Test Plan:
- Reset then idle → full = 0, flush = 0, upd_valid = 0, err = 0, counters 0.
- Push pc=0x100, je=1, jdest=0x200; then ex_valid pc=0x100, is_jmp=1, taken=1, target=0x200 → next cycle upd_valid=1, upd_taken=1, upd_dest=0x200, flush=0, branch_cnt=1.
- Push pc=0x104 je=1 jdest=0x300; resolve taken=0 → flush=1, redirect_pc=0x108, mispred_cnt=1. Also push 0x108 in the resolve cycle → FIFO empty afterwards.
- Predicted taken to 0x300, actual taken to 0x340 → flush=1, redirect_pc=0x340. Non-branch with je=1 → flush=1, upd_valid=0, redirect_pc=pc+4.
- Push DEPTH entries → full=1 and the extra push is dropped. Simultaneous push+pop with count=DEPTH-1 → count stays, full=0. Then resolve all entries in order: pointer wrap, correct PCs, err=0.
- ex_valid on empty FIFO → err=1 and stays set, no flush. Head pc 0x100 vs ex_pc 0x104 → err=1. Asserting rst mid-stream clears the FIFO, err and counters.
